// File: rtl/sequence_source.sv
// Burst generator: ramp or Galois-LFSR data words under a valid/ready handshake.
// Define SEQ_LFSR_EN to build LFSR support; otherwise every burst is a ramp.
module sequence_source #(
  parameter int                    data_width = 10,
  parameter int                    N          = 4,
  parameter int                    STEP       = 1,
  parameter logic [data_width-1:0] LFSR_TAPS  = data_width'(10'h240)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic [data_width-1:0] seed,
  input  logic [7:0]            len,
  input  logic                  mode,
  input  logic                  ready,
  output logic [data_width-1:0] data,
  output logic                  valid,
  output logic [7:0]            beat_idx,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [8:0] DEF_LEN = 9'(2 * N);

  state_t                state_q, state_d;
  logic [data_width-1:0] data_q, data_d;
  logic [7:0]            idx_q, idx_d;
  logic [7:0]            last_q, last_d;
  logic [data_width-1:0] step_val;
  logic [data_width-1:0] seed_eff;
  logic [8:0]            len_eff;
  logic                  accept;

  assign accept  = (state_q == IDLE) && start;
  assign len_eff = (len == 8'd0) ? DEF_LEN : {1'b0, len};

`ifdef SEQ_LFSR_EN
  logic                  lfsr_q, lfsr_d;
  logic [data_width-1:0] lfsr_nxt;

  assign lfsr_nxt = (data_q >> 1) ^ (data_q[0] ? LFSR_TAPS : '0);
  assign step_val = lfsr_q ? lfsr_nxt
                           : data_q + data_width'(STEP);
  // An all-zero LFSR state never leaves zero.
  assign seed_eff = (mode && seed == '0) ? data_width'(1) : seed;
  assign lfsr_d   = accept ? mode : lfsr_q;

  always_ff @(posedge clk) begin
    if (!rst_n) lfsr_q <= 1'b0;
    else        lfsr_q <= lfsr_d;
  end
`else
  logic unused_mode;

  assign unused_mode = mode;
  assign step_val    = data_q + data_width'(STEP);
  assign seed_eff    = seed;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      last_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN: begin
        if (stop)
          state_d = IDLE;
        else if (ready && idx_q == last_q)
          state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A beat accepted alongside stop still advances the datapath.
  always_comb begin
    data_d = data_q;
    idx_d  = idx_q;
    last_d = last_q;
    if (accept) begin
      data_d = seed_eff;
      idx_d  = '0;
      last_d = 8'(len_eff - 9'd1);
    end else if (state_q == RUN && ready) begin
      data_d = step_val;
      idx_d  = idx_q + 8'd1;
    end
  end

  always_comb begin
    valid    = (state_q == RUN);
    done     = (state_q == DONE);
    data     = data_q;
    beat_idx = idx_q;
  end

endmodule

// File: doc/sequence_source.md
SEQUENCE_SOURCE -- requirements
Module: sequence_source

Interface
REQ-001 Parameter: data_width, default 10, width of the generated data word.
REQ-002 Parameter: N, default 4; default burst length is 2*N beats.
REQ-003 Parameter: STEP, default 1, ramp increment per accepted beat.
REQ-004 Parameter: LFSR_TAPS, default 10'h240 (x^10+x^7+1), Galois feedback mask, data_width bits.
REQ-005 The block SHALL have one clock and a synchronous, active-low reset.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst_n  input  1  synchronous active-low reset.
REQ-008 start  input  1  request a burst; sampled only in IDLE.
REQ-009 stop  input  1  abort the current burst.
REQ-010 seed  input  data_width  first data value, captured on an accepted start.
REQ-011 len  input  8  burst length in beats, captured on an accepted start; 0 means 2*N.
REQ-012 mode  input  1  0 = ramp, 1 = LFSR; captured on an accepted start.
REQ-013 ready  input  1  downstream accepts a beat; tie high for an always-accepting consumer such as the past-sequence adder.
REQ-014 data  output  data_width  current beat value.
REQ-015 valid  output  1  data holds a beat.
REQ-016 beat_idx  output  8  index of the current beat, 0-based.
REQ-017 done  output  1  one-cycle pulse when a burst completes normally.

Function
REQ-018 The FSM SHALL have states IDLE, RUN and DONE.
REQ-019 IDLE with start=1 SHALL go to RUN next cycle, with data=seed, beat_idx=0 and valid=1 (latency 1 cycle).
REQ-020 A transfer SHALL occur on each cycle with valid=1 and ready=1.
REQ-021 data, valid and beat_idx SHALL hold unchanged while valid=1 and ready=0.
REQ-022 On a transfer in ramp mode, data SHALL become (data+STEP) mod 2^data_width, so it wraps without a flag.
REQ-023 On a transfer in LFSR mode, data SHALL advance one Galois step: shift right, and XOR in LFSR_TAPS when the shifted-out bit is 1.
REQ-024 A transfer SHALL increment beat_idx; the transfer of beat len-1 SHALL move to DONE with valid=0.
REQ-025 DONE SHALL assert done=1 for exactly one cycle and then return to IDLE.
REQ-026 In RUN, stop=1 SHALL go to IDLE next cycle with valid=0 and no done pulse.
REQ-027 A transfer that happens in the same cycle as stop SHALL count as delivered.
REQ-028 If stop and the final transfer coincide, stop SHALL take priority, giving no done pulse.
REQ-029 start SHALL be ignored in RUN and DONE.
REQ-030 stop SHALL be ignored in IDLE and DONE.
REQ-031 start and stop together in IDLE SHALL be treated as start only.

Reset
REQ-032 rst_n=0 at a rising clk edge SHALL force IDLE, data=0, valid=0, beat_idx=0 and done=0, overriding every other input.
REQ-033 Reset mid-burst SHALL drop the burst with no done pulse.
REQ-034 After reset is released, the next start SHALL behave as REQ-019.

Configuration
REQ-035 Macro SEQ_LFSR_EN SHALL control LFSR support.
REQ-036 With SEQ_LFSR_EN defined, mode=1 SHALL select LFSR generation per REQ-023.
REQ-037 With SEQ_LFSR_EN defined, a captured seed of 0 in LFSR mode SHALL be replaced by 1 to avoid lockup.
REQ-038 Without SEQ_LFSR_EN, the mode port SHALL remain but be ignored, the LFSR logic SHALL not be synthesized, and all bursts SHALL be ramp.

Verification
REQ-039 Ramp with ready=1: seed=5, len=4, mode=0 -> data 5,6,7,8 with valid=1 on the 4 cycles after start, then done=1 for one cycle.
REQ-040 Wrap: seed=1022, len=4 -> data 1022,1023,0,1.
REQ-041 Backpressure: ready=0 for 3 cycles on beat 1 -> data and beat_idx hold for those 3 cycles, with no beat lost or repeated.
REQ-042 Abort: stop on beat 2 of len=0 (8 beats) -> valid=0 next cycle, no done, and IDLE accepts a new start.
REQ-043 Reset: rst_n=0 on beat 3 -> all outputs 0 the next cycle, and done is never asserted.
REQ-044 LFSR (SEQ_LFSR_EN): seed=0, mode=1, len=3 -> data 1, 0x240, 0x120.
